// File: rtl/rgmii_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one RGMII transmit byte stream between
// several egress queues, with inter-frame gap insertion and oversize-frame truncation.
module rgmii_tx_arbiter #(
  parameter int NUM_REQUESTERS  = 4,
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int IFG_CYCLES      = 12
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_REQUESTERS-1:0]   req_valid,
  input  logic [8*NUM_REQUESTERS-1:0] req_data,
  input  logic [NUM_REQUESTERS-1:0]   req_last,
  output logic [NUM_REQUESTERS-1:0]   req_ready,
  output logic                        tx_valid,
  output logic [7:0]                  tx_data,
  output logic                        tx_last,
  input  logic                        tx_ready,
  output logic                        grant_valid,
  output logic [2:0]                  grant_index,
  output logic                        frame_truncated
);

  localparam int BW = $clog2(MAX_FRAME_BYTES + 1);
  localparam int GW = $clog2(IFG_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [2:0]      ptr_r, ptr_s;
  logic [2:0]      grant_r, grant_s;
  logic [BW-1:0]   byte_cnt_r, byte_cnt_s;
  logic [GW-1:0]   gap_cnt_r, gap_cnt_s;
  logic            trunc_r, trunc_s;

  logic            hi_found_s, lo_found_s;
  logic [2:0]      hi_idx_s, lo_idx_s, win_idx_s;
  logic            sel_valid_s, sel_last_s;
  logic [7:0]      sel_data_s;
  logic            at_max_s;
  logic            port_ready_s;

  // Round-robin search: first requester above the pointer wins, else first at or below it
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = 3'd0;
    lo_idx_s   = 3'd0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (req_valid[i] && (3'(i) > ptr_r) && !hi_found_s) begin
        hi_found_s = 1'b1;
        hi_idx_s   = 3'(i);
      end else if (req_valid[i] && (3'(i) <= ptr_r) && !lo_found_s) begin
        lo_found_s = 1'b1;
        lo_idx_s   = 3'(i);
      end else begin
        hi_found_s = hi_found_s;
      end
    end
    if (hi_found_s) begin
      win_idx_s = hi_idx_s;
    end else begin
      win_idx_s = lo_idx_s;
    end
  end

  // Select the granted requester's byte lane
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = 8'd0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      sel_valid_s = sel_valid_s | (req_valid[i] & (grant_r == 3'(i)));
      sel_last_s  = sel_last_s  | (req_last[i]  & (grant_r == 3'(i)));
      sel_data_s  = sel_data_s  | (req_data[8*i +: 8] & {8{grant_r == 3'(i)}});
    end
  end

  // The byte about to transfer would be number MAX_FRAME_BYTES of the frame
  assign at_max_s = (byte_cnt_r == BW'(MAX_FRAME_BYTES - 1));

  // Next-state logic and the combinational pass-through toward the tx path
  always_comb begin
    state_s      = state_r;
    ptr_s        = ptr_r;
    grant_s      = grant_r;
    byte_cnt_s   = byte_cnt_r;
    gap_cnt_s    = gap_cnt_r;
    trunc_s      = 1'b0;
    port_ready_s = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'd0;
    tx_last      = 1'b0;
    grant_valid  = 1'b0;
    req_ready    = {NUM_REQUESTERS{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (enable && (|req_valid)) begin
          grant_s    = win_idx_s;
          ptr_s      = win_idx_s;
          byte_cnt_s = {BW{1'b0}};
          state_s    = ST_STREAM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        grant_valid  = 1'b1;
        port_ready_s = tx_ready;
        tx_valid     = sel_valid_s;
        tx_data      = sel_data_s;
        tx_last      = sel_last_s | at_max_s;
        if (sel_valid_s && tx_ready) begin
          byte_cnt_s = byte_cnt_r + BW'(1);
          if (sel_last_s) begin
            gap_cnt_s = {GW{1'b0}};
            state_s   = ST_GAP;
          end else if (at_max_s) begin
            trunc_s = 1'b1;
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_STREAM;
          end
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        grant_valid  = 1'b1;
        port_ready_s = 1'b1;
        if (sel_valid_s && sel_last_s) begin
          gap_cnt_s = {GW{1'b0}};
          state_s   = ST_GAP;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GW'(IFG_CYCLES - 1)) begin
          gap_cnt_s = {GW{1'b0}};
          state_s   = ST_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + GW'(1);
          state_s   = ST_GAP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      req_ready[i] = port_ready_s & (grant_r == 3'(i));
    end
  end

  // State and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 3'(NUM_REQUESTERS - 1);
      grant_r    <= 3'd0;
      byte_cnt_r <= {BW{1'b0}};
      gap_cnt_r  <= {GW{1'b0}};
      trunc_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      grant_r    <= grant_s;
      byte_cnt_r <= byte_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
      trunc_r    <= trunc_s;
    end
  end

  assign grant_index     = grant_r;
  assign frame_truncated = trunc_r;

endmodule

// File: tb/tb_rgmii_tx_arbiter.sv
// Directed-plus-random bench for rgmii_tx_arbiter: requester queues feed the DUT and a
// frame-level reference model predicts grant order, forwarded bytes and truncations.
module tb_rgmii_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 1522;
  localparam int IFG  = 12;

  logic             clock = 1'b0;
  logic             reset, enable, tx_ready;
  logic [N-1:0]     req_valid, req_last, req_ready;
  logic [8*N-1:0]   req_data;
  logic             tx_valid, tx_last, grant_valid, frame_truncated;
  logic [7:0]       tx_data;
  logic [2:0]       grant_index;

  always #5 clock = ~clock;

  rgmii_tx_arbiter #(.NUM_REQUESTERS(N), .MAX_FRAME_BYTES(MAXB), .IFG_CYCLES(IFG)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .grant_valid(grant_valid), .grant_index(grant_index), .frame_truncated(frame_truncated)
  );

  int tests = 0;
  int fails = 0;

  // requester-side queues driving the DUT
  logic [7:0] dq_data[N][$];
  logic       dq_last[N][$];
  // reference model: whole frames per requester
  logic [7:0] mq_data[N][$];
  int         mq_len[N][$];
  int         m_ptr;
  // expected and observed streams
  logic [7:0] exp_data[$];
  logic       exp_last[$];
  logic [2:0] exp_src[$];
  logic [2:0] exp_gnt[$];
  int         exp_trunc;
  logic [7:0] got_data[$];
  logic       got_last[$];
  logic [2:0] got_src[$];
  logic [2:0] got_gnt[$];
  int         gap_log[$];
  int         trunc_cnt;
  int         low_run;
  bit         have_fall;
  logic       prev_gv;

  logic rst_req, en_req;
  bit   rdy_rand;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input int r, input int len);
    logic [7:0] v;
    for (int b = 0; b < len; b++) begin
      v = 8'($urandom);
      dq_data[r].push_back(v);
      dq_last[r].push_back(b == len - 1);
      mq_data[r].push_back(v);
    end
    mq_len[r].push_back(len);
  endtask

  // Frame-level model: round-robin over requesters holding whole frames
  task automatic model_resolve();
    int  c, len, keep;
    bit  found;
    logic [7:0] d;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      c = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && mq_len[(m_ptr + k) % N].size() > 0) begin
          found = 1'b1;
          c = (m_ptr + k) % N;
        end
      end
      if (found) begin
        len  = mq_len[c].pop_front();
        keep = (len > MAXB) ? MAXB : len;
        for (int j = 0; j < len; j++) begin
          d = mq_data[c].pop_front();
          if (j < keep) begin
            exp_data.push_back(d);
            exp_last.push_back(j == keep - 1);
            exp_src.push_back(3'(c));
          end
        end
        if (len > MAXB) exp_trunc++;
        exp_gnt.push_back(3'(c));
        m_ptr = c;
      end
    end
  endtask

  task automatic clear_obs();
    exp_data.delete(); exp_last.delete(); exp_src.delete(); exp_gnt.delete();
    got_data.delete(); got_last.delete(); got_src.delete(); got_gnt.delete();
    gap_log.delete();
    exp_trunc = 0; trunc_cnt = 0; low_run = 0; have_fall = 1'b0;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      dq_data[i].delete(); dq_last[i].delete();
      mq_data[i].delete(); mq_len[i].delete();
    end
  endtask

  function automatic bit queues_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (dq_data[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // One clock: drive at negedge, sample 2 time units later (before the posedge)
  task automatic step();
    @(negedge clock);
    reset    = rst_req;
    enable   = en_req;
    tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (dq_data[i].size() > 0);
      req_data[8*i +: 8] = (dq_data[i].size() > 0) ? dq_data[i][0] : 8'd0;
      req_last[i]        = (dq_data[i].size() > 0) ? dq_last[i][0] : 1'b0;
    end
    #2;
    if (tx_valid && tx_ready) begin
      got_data.push_back(tx_data);
      got_last.push_back(tx_last);
      got_src.push_back(grant_index);
    end
    if (frame_truncated) trunc_cnt++;
    if (grant_valid && !prev_gv) begin
      got_gnt.push_back(grant_index);
      if (have_fall) gap_log.push_back(low_run);
    end
    if (!grant_valid && prev_gv) begin
      have_fall = 1'b1;
      low_run   = 0;
    end
    if (!grant_valid) low_run++;
    prev_gv = grant_valid;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        void'(dq_data[i].pop_front());
        void'(dq_last[i].pop_front());
      end
    end
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    int idle = 0;
    while (n < budget && idle <= IFG + 2) begin
      step();
      n++;
      if (queues_empty() && !grant_valid) idle++;
      else idle = 0;
    end
    chk({tag, "_complete"}, 64'(idle > IFG + 2), 64'd1);
  endtask

  task automatic check_scenario(input string tag, input bit check_gaps);
    int bad, lim;
    chk({tag, "_beats"}, 64'(got_data.size()), 64'(exp_data.size()));
    lim = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    bad = 0;
    for (int i = 0; i < lim; i++)
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_src[i] !== exp_src[i]) bad++;
    chk({tag, "_byte_errors"}, 64'(bad), 64'd0);
    chk({tag, "_grants"}, 64'(got_gnt.size()), 64'(exp_gnt.size()));
    lim = (got_gnt.size() < exp_gnt.size()) ? got_gnt.size() : exp_gnt.size();
    bad = 0;
    for (int i = 0; i < lim; i++) if (got_gnt[i] !== exp_gnt[i]) bad++;
    chk({tag, "_grant_order"}, 64'(bad), 64'd0);
    chk({tag, "_trunc_pulses"}, 64'(trunc_cnt), 64'(exp_trunc));
    if (check_gaps) begin
      // a pending request sees IFG gap cycles plus the one-cycle grant decision
      chk({tag, "_gap_count"}, 64'(gap_log.size()), 64'(exp_gnt.size() - 1));
      bad = 0;
      foreach (gap_log[i]) if (gap_log[i] != IFG + 1) bad++;
      chk({tag, "_gap_len"}, 64'(bad), 64'd0);
    end
    clear_obs();
  endtask

  task automatic apply_reset();
    rst_req = 1'b1;
    step();
    step();
    clear_queues();
    m_ptr   = N - 1;
    rst_req = 1'b0;
    clear_obs();
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; tx_ready = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    rst_req = 1'b1; en_req = 1'b1; rdy_rand = 1'b0; prev_gv = 1'b0;
    m_ptr = N - 1;
    clear_obs();

    // reset state
    step(); step(); step();
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_tx_last", 64'(tx_last), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_grant_valid", 64'(grant_valid), 64'd0);
    chk("rst_grant_index", 64'(grant_index), 64'd0);
    chk("rst_frame_truncated", 64'(frame_truncated), 64'd0);
    rst_req = 1'b0;
    clear_obs();

    // S1: single requester, 64-byte frame then a re-grant of the same requester
    load_frame(2, 64);
    load_frame(2, 5);
    model_resolve();
    run_until_idle("s1", 400);
    check_scenario("s1", 1'b1);

    // S2: three requesters pending, requester 0 with two frames
    apply_reset();
    load_frame(0, 4); load_frame(0, 4); load_frame(1, 4); load_frame(3, 4);
    model_resolve();
    run_until_idle("s2", 400);
    check_scenario("s2", 1'b1);

    // S3: oversize frame truncated and drained; exact-max frame not flagged
    load_frame(1, 1600);
    load_frame(0, MAXB);
    model_resolve();
    run_until_idle("s3", 5000);
    check_scenario("s3", 1'b1);

    // S4: random tx_ready back-pressure
    rdy_rand = 1'b1;
    load_frame(3, 100);
    load_frame(2, 37);
    model_resolve();
    run_until_idle("s4", 2000);
    check_scenario("s4", 1'b1);
    rdy_rand = 1'b0;

    // S5: enable dropped mid-frame
    load_frame(0, 30);
    load_frame(2, 8);
    model_resolve();
    n = 0;
    while (got_data.size() < 10 && n < 200) begin step(); n++; end
    chk("s5_reached_byte10", 64'(got_data.size()), 64'd10);
    en_req = 1'b0;
    for (int i = 0; i < 100; i++) step();
    chk("s5_frame_finished", 64'(got_data.size()), 64'd30);
    chk("s5_no_grant_disabled", 64'(got_gnt.size()), 64'd1);
    chk("s5_idle_disabled", 64'(grant_valid), 64'd0);
    en_req = 1'b1;
    step();
    step();
    chk("s5_grant_after_enable", 64'(grant_valid), 64'd1);
    chk("s5_grant_index", 64'(grant_index), 64'd2);
    run_until_idle("s5", 400);
    check_scenario("s5", 1'b0);

    // S6: reset mid-frame, then all requesters compete
    load_frame(3, 40);
    n = 0;
    while (got_data.size() < 20 && n < 200) begin step(); n++; end
    rst_req = 1'b1;
    step();
    step();
    chk("s6_tx_valid", 64'(tx_valid), 64'd0);
    chk("s6_tx_data", 64'(tx_data), 64'd0);
    chk("s6_tx_last", 64'(tx_last), 64'd0);
    chk("s6_req_ready", 64'(req_ready), 64'd0);
    chk("s6_grant_valid", 64'(grant_valid), 64'd0);
    chk("s6_grant_index", 64'(grant_index), 64'd0);
    chk("s6_frame_truncated", 64'(frame_truncated), 64'd0);
    clear_queues();
    clear_obs();
    m_ptr   = N - 1;
    rst_req = 1'b0;
    for (int r = 0; r < N; r++) load_frame(r, 6);
    model_resolve();
    run_until_idle("s6", 600);
    chk("s6_first_grant", (got_gnt.size() > 0) ? 64'(got_gnt[0]) : 64'hFFFF, 64'd0);
    check_scenario("s6", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
